// File: rtl/adc_timing_pkg.sv
// Shared types and constants for the runtime-configurable ADS816x timing calculator.
// Times are in NiS units, where 2^30 NiS equals one second.
package adc_timing_pkg;

  typedef enum logic [1:0] {
    ADS8168  = 2'd0,
    ADS8167  = 2'd1,
    ADS8166  = 2'd2,
    ADS_RSVD = 2'd3
  } adc_model_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL_CONV,
    ST_MUL_CYCLE,
    ST_MUL_MISO,
    ST_COMBINE,
    ST_DONE
  } state_e;

  localparam int NIS_W     = 16;
  localparam int FRAC_BITS = 30;

  // Rounding addends used before dropping the 30 fractional bits of a product.
  localparam logic [FRAC_BITS:0] NIS_ONE      = 31'h4000_0000;
  localparam logic [FRAC_BITS:0] NIS_CEIL_ADD = 31'h3FFF_FFFF;

  localparam logic [NIS_W-1:0] MISO_DELAY_NIS = 16'd5;

  // The reserved model code falls through to the ADS8166 constants.
  function automatic logic [NIS_W-1:0] conv_nis(input adc_model_e m);
    case (m)
      ADS8168: return 16'd709;
      ADS8167: return 16'd1289;
      default: return 16'd2685;
    endcase
  endfunction

  function automatic logic [NIS_W-1:0] cycle_nis(input adc_model_e m);
    case (m)
      ADS8168: return 16'd1074;
      ADS8167: return 16'd2148;
      default: return 16'd4295;
    endcase
  endfunction

endpackage

// File: rtl/adc_timing_calc_multi_if.sv
// Configuration/result bundle between the SPI clock registers and the timing calculator.
interface adc_timing_calc_multi_if #(
  parameter int N_CS_WIDTH       = 8,
  parameter int MISO_DELAY_WIDTH = 3
);
  logic [31:0]                 spi_clk_freq_hz;
  logic [1:0]                  adc_model;
  logic [3:0]                  cs_margin;
  logic                        calc;
  logic [N_CS_WIDTH-1:0]       n_cs_high_time;
  logic [MISO_DELAY_WIDTH-1:0] miso_halfclk_delay;
  logic                        sat;
  logic                        cfg_err;
  logic                        busy;
  logic                        done;
  logic                        lock_viol;

  modport master (
    output spi_clk_freq_hz, adc_model, cs_margin, calc,
    input  n_cs_high_time, miso_halfclk_delay, sat, cfg_err, busy, done, lock_viol
  );

  modport slave (
    input  spi_clk_freq_hz, adc_model, cs_margin, calc,
    output n_cs_high_time, miso_halfclk_delay, sat, cfg_err, busy, done, lock_viol
  );
endinterface

// File: rtl/adc_serial_mult.sv
// Serial shift-add multiplier: 32-bit multiplier times a MUL_BITS constant, one bit per step.
// product presents the running sum including the current step, so it is final while last is high.
module adc_serial_mult #(
  parameter  int MUL_BITS = 13,
  localparam int PROD_W   = 32 + MUL_BITS
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic                step,
  input  logic [31:0]         multiplier,
  input  logic [MUL_BITS-1:0] multiplicand,
  output logic [PROD_W-1:0]   product,
  output logic                last
);
  localparam int IDX_W = $clog2(MUL_BITS);

  logic [IDX_W-1:0]  idx_q;
  logic [PROD_W-1:0] acc_q;
  logic [PROD_W-1:0] term;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    term = '0;
    if (multiplicand[idx_q]) term = PROD_W'(multiplier) << idx_q;
    product = ((idx_q == '0) ? '0 : acc_q) + term;
  end

  assign last = step && (idx_q == IDX_W'(MUL_BITS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx_q <= '0;
      acc_q <= '0;
    end else if (start) begin
      idx_q <= '0;
    end else if (step) begin
      acc_q <= product;
      idx_q <= last ? '0 : idx_q + 1'b1;
    end
  end

endmodule

// File: rtl/adc_timing_calc_multi.sv
// Runtime-selectable ADS816x n_CS high time / MISO delay calculator with CS margin,
// saturation, sticky input-lock violation and fixed 3*MUL_BITS+2 cycle latency.
module adc_timing_calc_multi
  import adc_timing_pkg::*;
#(
  parameter int N_CS_WIDTH       = 8,
  parameter int MISO_DELAY_WIDTH = 3,
  parameter int OTF_CMD_BITS     = 16,
  parameter int MIN_CS_CYCLES    = 3,
  parameter int MUL_BITS         = 13
) (
  input logic                    clk,
  input logic                    resetn,
  adc_timing_calc_multi_if.slave bus
);
  localparam int PROD_W = 32 + MUL_BITS;
  localparam int CYC_W  = PROD_W + 1 - FRAC_BITS;
  localparam logic [CYC_W:0]   N_LIMIT  = (CYC_W + 1)'(2 ** N_CS_WIDTH);
  localparam logic [CYC_W-1:0] MISO_MAX = CYC_W'(2 ** MISO_DELAY_WIDTH - 1);

  state_e state_q, state_d;

  logic [31:0] freq_q;
  logic [1:0]  model_q;
  logic [3:0]  margin_q;

  logic [CYC_W-1:0] conv_q, cyc_q, ceil_cyc, rnd_cyc, conv_floor, cyc_sub;
  logic [MISO_DELAY_WIDTH-1:0] miso_q, miso_cap, miso_out_q;
  logic [CYC_W:0] n_need;
  logic [N_CS_WIDTH-1:0] n_cs_q;
  logic sat_q, cfg_q, busy_q, done_q, lock_q;
  logic lock_hit;

  logic                mul_start, mul_step, mul_last;
  logic [MUL_BITS-1:0] mcand;
  logic [PROD_W-1:0]   product;

  assign mul_start = (state_q == ST_IDLE);
  assign mul_step  = (state_q == ST_MUL_CONV) || (state_q == ST_MUL_CYCLE) || (state_q == ST_MUL_MISO);

  always_comb begin
    mcand = '0;
    case (state_q)
      ST_MUL_CONV:  mcand = MUL_BITS'(conv_nis(adc_model_e'(model_q)));
      ST_MUL_CYCLE: mcand = MUL_BITS'(cycle_nis(adc_model_e'(model_q)));
      ST_MUL_MISO:  mcand = MUL_BITS'(MISO_DELAY_NIS);
      default:      mcand = '0;
    endcase
  end

  adc_serial_mult #(.MUL_BITS(MUL_BITS)) u_mult (
    .clk          (clk),
    .resetn       (resetn),
    .start        (mul_start),
    .step         (mul_step),
    .multiplier   (freq_q),
    .multiplicand (mcand),
    .product      (product),
    .last         (mul_last)
  );

  // Drop the NiS fraction: ceiling for the CS terms, round-up-by-one for the MISO term.
  assign ceil_cyc = CYC_W'(({1'b0, product} + {{(PROD_W - FRAC_BITS){1'b0}}, NIS_CEIL_ADD}) >> FRAC_BITS);
  assign rnd_cyc  = CYC_W'(({1'b0, product} + {{(PROD_W - FRAC_BITS){1'b0}}, NIS_ONE}) >> FRAC_BITS);

  assign conv_floor = (ceil_cyc < CYC_W'(MIN_CS_CYCLES)) ? CYC_W'(MIN_CS_CYCLES) : ceil_cyc;
  assign cyc_sub    = (ceil_cyc > CYC_W'(OTF_CMD_BITS)) ? ceil_cyc - CYC_W'(OTF_CMD_BITS) : '0;
  assign miso_cap   = (rnd_cyc > MISO_MAX) ? '1 : rnd_cyc[MISO_DELAY_WIDTH-1:0];
  assign n_need     = {1'b0, ((conv_q > cyc_q) ? conv_q : cyc_q)} + (CYC_W + 1)'(margin_q);

  assign lock_hit = (state_q != ST_IDLE) &&
                    ((bus.spi_clk_freq_hz != freq_q) || (bus.adc_model != model_q) ||
                     (bus.cs_margin != margin_q));

  // A lock violation outranks a simultaneous calc drop; both return to IDLE.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_IDLE) begin
      if (bus.calc && !lock_q) state_d = ST_MUL_CONV;
    end else if (lock_hit || !bus.calc) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_MUL_CONV:  if (mul_last) state_d = ST_MUL_CYCLE;
        ST_MUL_CYCLE: if (mul_last) state_d = ST_MUL_MISO;
        ST_MUL_MISO:  if (mul_last) state_d = ST_COMBINE;
        ST_COMBINE:   state_d = ST_DONE;
        default:      state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      freq_q     <= '0;
      model_q    <= '0;
      margin_q   <= '0;
      conv_q     <= '0;
      cyc_q      <= '0;
      miso_q     <= '0;
      n_cs_q     <= '0;
      miso_out_q <= MISO_DELAY_WIDTH'(1);
      sat_q      <= 1'b0;
      cfg_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      lock_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE) begin
        if (!bus.calc) begin
          lock_q <= 1'b0;
        end else if (!lock_q) begin
          freq_q   <= bus.spi_clk_freq_hz;
          model_q  <= bus.adc_model;
          margin_q <= bus.cs_margin;
          busy_q   <= 1'b1;
          done_q   <= 1'b0;
        end
      end else if (lock_hit) begin
        lock_q <= 1'b1;
        busy_q <= 1'b0;
        done_q <= 1'b0;
      end else if (!bus.calc) begin
        busy_q <= 1'b0;
        done_q <= 1'b0;
      end else begin
        if (mul_last) begin
          case (state_q)
            ST_MUL_CONV:  conv_q <= conv_floor;
            ST_MUL_CYCLE: cyc_q  <= cyc_sub;
            ST_MUL_MISO:  miso_q <= miso_cap;
            default:      ;
          endcase
        end
        if (state_q == ST_COMBINE) begin
          sat_q      <= (n_need > N_LIMIT);
          n_cs_q     <= (n_need > N_LIMIT) ? '1 : N_CS_WIDTH'(n_need - 1'b1);
          miso_out_q <= miso_q;
          cfg_q      <= (adc_model_e'(model_q) == ADS_RSVD);
        end
        if (state_q == ST_DONE) begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
      end
    end
  end

  assign bus.n_cs_high_time     = n_cs_q;
  assign bus.miso_halfclk_delay = miso_out_q;
  assign bus.sat                = sat_q;
  assign bus.cfg_err            = cfg_q;
  assign bus.busy               = busy_q;
  assign bus.done               = done_q;
  assign bus.lock_viol          = lock_q;

endmodule

// File: doc/adc_timing_calc_multi.md
Name: adc_timing_calc_multi

Overview:
Runtime-configurable successor to the single-model ADS816x timing calculator. It computes the n_CS high time and the MISO half-clock delay for any ADS816x model, selected at run time rather than at build time. It also adds a programmable CS margin, a saturation flag, a sticky lock-violation flag and a fixed, deterministic latency. It sits between the SPI clock configuration registers and the ADC SPI core, and is shared by all ADC channels of one SPI clock domain.

Parameters:
N_CS_WIDTH, 8, width of n_cs_high_time; maximum encoded high time is 2^N_CS_WIDTH cycles.
MISO_DELAY_WIDTH, 3, width of miso_halfclk_delay; the result is capped at 2^MISO_DELAY_WIDTH-1.
OTF_CMD_BITS, 16, SPI command bits subtracted from the cycle-time requirement.
MIN_CS_CYCLES, 3, floor applied to the conversion-time cycle count.
MUL_BITS, 13, serial multiplier step count; must be at least the bit width of the largest NiS constant.

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
spi_clk_freq_hz  in  32  SPI clock frequency in Hz
adc_model  in  2  0=ADS8168, 1=ADS8167, 2=ADS8166, 3=reserved (treated as ADS8166, flags cfg_err)
cs_margin  in  4  extra CS-high cycles added before saturation
calc  in  1  level request; hold high to compute and keep the result
n_cs_high_time  out  N_CS_WIDTH  CS high cycles minus 1
miso_halfclk_delay  out  MISO_DELAY_WIDTH  MISO sampling delay in half clocks
sat  out  1  CS requirement exceeded 2^N_CS_WIDTH and was clipped
cfg_err  out  1  adc_model==3 latched for the current calculation
busy  out  1  calculation in progress
done  out  1  results valid for the latched inputs
lock_viol  out  1  sticky; inputs changed during busy or done

Behaviour:
- Units: NiS, where 2^30 NiS = 1 s. The product f*T/2^30 gives a cycle count.
- NiS constants (conv/cycle): ADS8168 709/1074, ADS8167 1289/2148, ADS8166 2685/4295. MISO_DELAY_NiS = 5.
- Reset (async assert, sync deassert handled upstream): n_cs_high_time=0, miso_halfclk_delay=1, sat=0, cfg_err=0, busy=0, done=0, lock_viol=0, state=IDLE.
- States: IDLE, MUL_CONV, MUL_CYCLE, MUL_MISO, COMBINE, DONE.
- IDLE: lock_viol is cleared only here, and only while calc is low.
- Start condition: calc=1 and lock_viol=0. On start, latch freq, model and cs_margin, set busy=1, clear done, and enter MUL_CONV.
- Each MUL_* state lasts exactly MUL_BITS cycles. On each cycle the serial multiplier adds freq<<i when const[i] is set. The 45-bit product is captured on the last cycle.
- Arithmetic:
  - conv = max(ceil(P_conv/2^30), MIN_CS_CYCLES).
  - cyc = ceil(P_cycle/2^30) - OTF_CMD_BITS, floored at 0.
  - ceil is implemented as (P + 2^30-1)>>30.
  - miso = (P_miso + 2^30)>>30, capped at 2^MISO_DELAY_WIDTH-1.
- COMBINE (1 cycle):
  - n = max(conv, cyc) + cs_margin.
  - If n > 2^N_CS_WIDTH: n_cs_high_time = all-ones and sat=1. Otherwise n_cs_high_time = n-1 and sat=0.
  - Write miso_halfclk_delay and cfg_err.
- Latency: done rises on edge 3*MUL_BITS+2, counting the start edge as 0 (41 at default). busy falls on the same edge.
- DONE: holds the outputs and done=1 while calc stays high.
- calc low in any non-IDLE state: go to IDLE next edge, clear done and busy, and keep the last outputs.
- Lock check: in any non-IDLE state, if spi_clk_freq_hz, adc_model or cs_margin differs from its latched value, then:
  - lock_viol=1 (sticky), done=0, busy=0, state=IDLE;
  - outputs keep their previous values;
  - no restart happens until calc is deasserted for at least 1 cycle.
- Simultaneous calc fall and input change: lock_viol is set, because the lock check has priority.
- Asserting resetn mid-calculation forces all reset values immediately.

Decomposition:
- Package adc_timing_pkg holds the model enum, the NiS conversion/cycle/MISO constant table, the 2^30 rounding constants and the state encoding.
- Sub-module adc_serial_mult: a MUL_BITS-step shift-add unit with a 32-bit multiplier and a constant multiplicand. It has start/step/last outputs, is reused for all three products and is instantiated once.

Test Plan:
- ADS8168, f=50_000_000, margin 0 -> n_cs_high_time=34, miso=1, sat=0; done exactly 41 cycles after start.
- ADS8166, f=50_000_000: margin 0 -> 184; margin 15 -> 199. With N_CS_WIDTH=7 -> 127 and sat=1.
- ADS8168, f=1_000_000 -> conv floor applies, cyc=0, so n_cs_high_time=2 and miso=1.
- f=2_000_000_000 -> raw miso is 10, so miso_halfclk_delay=7 (cap).
- Change freq at cycle 20 of a calculation -> lock_viol=1, done stays 0, outputs unchanged. Holding calc gives no restart; after calc low then high, the calculation restarts and completes.
- adc_model=3 -> ADS8166 results with cfg_err=1. Assert resetn mid-MUL_CYCLE -> all outputs take their reset values.
